// File: rtl/serial_pattern_source_pkg.sv
// Shared definitions for the serial pattern source and the LED shift-chain tops:
// FSM state encodings and the default pattern width.
package serial_pattern_source_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a synchronised, debounced button level.
// A held level produces exactly one rise; it must fall before it can rise again.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/serial_pattern_source.sv
// Parallel-to-serial pattern source feeding the 8-bit LED shift chain: captures
// the pattern on a start press and emits one bit per enable tick.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no frame; data=0, busy=0; waiting for a start rise
//   ST_SHIFT | frame in progress; bit bit_idx of the shadow is on data
module serial_pattern_source
  import serial_pattern_source_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  // "repeat" is a reserved word in SystemVerilog, hence the suffix
  input  logic             repeat_en,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  output logic             data,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] ZERO = '0;

  state_t             state;
  logic [WIDTH-1:0]   shadow;
  logic               start_rise;
  logic [IDX_W-1:0]   next_idx;

  function automatic logic pick(input logic [WIDTH-1:0] s, input logic [IDX_W-1:0] i);
    pick = MSB_FIRST ? s[LAST - i] : s[i];
  endfunction

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .level (start),
    .rise  (start_rise)
  );

  assign next_idx = bit_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      data    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // abort drops the frame silently, overriding enable and start
        state   <= ST_IDLE;
        data    <= 1'b0;
        busy    <= 1'b0;
        bit_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_rise) begin
              shadow  <= pattern;
              bit_idx <= '0;
              data    <= pick(pattern, ZERO);
              busy    <= 1'b1;
              state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            // downstream samples data on this same enable edge
            if (enable) begin
              if (bit_idx == LAST) begin
                done    <= 1'b1;
                bit_idx <= '0;
                if (repeat_en) begin
                  data <= pick(shadow, ZERO);
                end else begin
                  data  <= 1'b0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              end else begin
                bit_idx <= next_idx;
                data    <= pick(shadow, next_idx);
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            data    <= 1'b0;
            busy    <= 1'b0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule
